// File: rtl/fp_result_packer.sv
// Two-stage RNE round/pack output stage for the FP adder, with valid/ready flow control.
// Optional flag output enabled by defining FP_PACK_FLAGS_EN.
module fp_result_packer #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int SHIFT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [MAN_W:0]         in_man,
  input  logic [2:0]             in_grs,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic                   in_ovf,
  input  logic                   in_unf,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result
`ifdef FP_PACK_FLAGS_EN
  , output logic [3:0]           out_flags
`endif
);
  localparam int FULL_W = MAN_W + 4;
  localparam int RES_W  = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {M_NORM, M_UNF, M_OVF, M_INV} mode_e;

  logic [2:1] vld_q;
  logic       s1_load, s2_load;

  assign s2_load   = !vld_q[2] | out_ready;
  assign s1_load   = !vld_q[1] | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_q[2];

  // ---- S1: case select and denormal shift
  mode_e              s1_mode_d, s1_mode_q;
  logic               s1_sign_q;
  logic [MAN_W:0]     s1_man_d, s1_man_q;
  logic               s1_g_d, s1_r_d, s1_s_d, s1_g_q, s1_r_q, s1_s_q;
  logic [EXP_W-1:0]   s1_exp_d, s1_exp_q;
  logic [FULL_W-1:0]  full, shifted, lost_mask;
  logic [31:0]        sh32;

  always_comb begin
    full      = {in_man, in_grs};
    sh32      = 32'(in_shift);
    shifted   = full >> sh32;
    lost_mask = ~({FULL_W{1'b1}} << sh32);
    s1_mode_d = M_NORM;
    s1_man_d  = in_man;
    s1_g_d    = in_grs[2];
    s1_r_d    = in_grs[1];
    s1_s_d    = in_grs[0];
    s1_exp_d  = in_exp;
    if (in_inv) begin
      s1_mode_d = M_INV;
    end else if (in_ovf) begin
      s1_mode_d = M_OVF;
    end else if (in_unf) begin
      s1_mode_d = M_UNF;
      s1_exp_d  = '0;
      // Shifting past every bit leaves only the sticky OR of the whole operand
      if (sh32 >= 32'(FULL_W)) begin
        s1_man_d = '0;
        s1_g_d   = 1'b0;
        s1_r_d   = 1'b0;
        s1_s_d   = |full;
      end else begin
        s1_man_d = shifted[FULL_W-1:3];
        s1_g_d   = shifted[2];
        s1_r_d   = shifted[1];
        s1_s_d   = shifted[0] | (|(full & lost_mask));
      end
    end
  end

  // ---- S2: RNE rounding and pack
  logic               inc;
  logic [MAN_W+1:0]   rnd;
  logic [EXP_W:0]     exp_inc;
  logic               rnd_inf;
  logic [RES_W-1:0]   res_d, res_q;

  always_comb begin
    inc     = s1_g_q & (s1_r_q | s1_s_q | s1_man_q[0]);
    rnd     = {1'b0, s1_man_q} + {{(MAN_W+1){1'b0}}, inc};
    exp_inc = {1'b0, s1_exp_q} + {{EXP_W{1'b0}}, 1'b1};
    rnd_inf = (s1_mode_q == M_NORM) & rnd[MAN_W+1] & (exp_inc >= {1'b0, {EXP_W{1'b1}}});
    res_d   = {s1_sign_q, s1_exp_q, rnd[MAN_W-1:0]};
    case (s1_mode_q)
      M_INV: res_d = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      M_OVF: res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      // Carry into the hidden bit promotes a denormal to the minimum normal
      M_UNF: res_d = {s1_sign_q, {{(EXP_W-1){1'b0}}, rnd[MAN_W]}, rnd[MAN_W-1:0]};
      default: begin
        if (rnd_inf)
          res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (rnd[MAN_W+1])
          res_d = {s1_sign_q, exp_inc[EXP_W-1:0], {MAN_W{1'b0}}};
      end
    endcase
  end

`ifdef FP_PACK_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  logic       f_ovf;
  always_comb begin
    f_ovf   = (s1_mode_q == M_OVF) | rnd_inf;
    flags_d = {s1_mode_q == M_INV,
               f_ovf,
               (s1_mode_q == M_UNF) & (res_d[RES_W-2:MAN_W] == '0),
               (((s1_mode_q == M_NORM) | (s1_mode_q == M_UNF)) & (s1_g_q | s1_r_q | s1_s_q)) | f_ovf};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     flags_q <= '0;
    else if (s2_load && vld_q[1]) flags_q <= flags_d;
  end
  assign out_flags = flags_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_mode_q <= M_NORM;
      s1_sign_q <= 1'b0;
      s1_man_q  <= '0;
      s1_g_q    <= 1'b0;
      s1_r_q    <= 1'b0;
      s1_s_q    <= 1'b0;
      s1_exp_q  <= '0;
      res_q     <= '0;
    end else begin
      if (s1_load) begin
        vld_q[1] <= in_valid;
        if (in_valid) begin
          s1_mode_q <= s1_mode_d;
          s1_sign_q <= in_sign;
          s1_man_q  <= s1_man_d;
          s1_g_q    <= s1_g_d;
          s1_r_q    <= s1_r_d;
          s1_s_q    <= s1_s_d;
          s1_exp_q  <= s1_exp_d;
        end
      end
      if (s2_load) begin
        vld_q[2] <= vld_q[1];
        if (vld_q[1]) res_q <= res_d;
      end
    end
  end

  assign out_result = res_q;

endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: directed vector table, stall sequence, random stream vs value model.
module tb_fp_result_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        in_sign = 1'b0;
  logic [23:0] in_man = '0;
  logic [2:0]  in_grs = '0;
  logic [7:0]  in_exp = '0;
  logic [9:0]  in_shift = '0;
  logic        in_ovf = 1'b0, in_unf = 1'b0, in_inv = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_result;

  fp_result_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_man(in_man), .in_grs(in_grs), .in_exp(in_exp),
    .in_shift(in_shift), .in_ovf(in_ovf), .in_unf(in_unf), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [23:0] man;
    logic [2:0]  grs;
    logic [7:0]  exp;
    logic [9:0]  shift;
    logic        ovf, unf, inv;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] res;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic        stalled = 1'b0;
  logic [31:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Exact-value RNE: quotient and remainder of the scaled mantissa, tie goes to even.
  function automatic logic [31:0] ref_model(input stim_t s);
    longint full, q, rem, half, sh, e;
    logic [63:0] qv, ev;
    if (s.inv) return 32'h7FFFFFFF;
    if (s.ovf) return {s.sign, 8'hFF, 23'h0};
    full = longint'({s.man, s.grs});
    if (s.unf) begin
      sh = longint'(s.shift) + 3;
      if (sh >= 40) return {s.sign, 31'h0};
      q    = full >> sh;
      rem  = full - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e  = (q >= (longint'(1) << 23)) ? 1 : 0;
      qv = q; ev = e;
      return {s.sign, ev[7:0], qv[22:0]};
    end
    q   = longint'(s.man);
    rem = longint'(s.grs);
    if (rem > 4 || (rem == 4 && q[0])) q = q + 1;
    e = longint'(s.exp);
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s.sign, 8'hFF, 23'h0};
    qv = q; ev = e;
    return {s.sign, ev[7:0], qv[22:0]};
  endfunction

  task automatic drive(input logic iv, input stim_t s);
    in_valid = iv;
    in_sign  = s.sign; in_man = s.man; in_grs = s.grs; in_exp = s.exp;
    in_shift = s.shift; in_ovf = s.ovf; in_unf = s.unf; in_inv = s.inv;
  endtask

  // One cycle of the streaming harness: stall stability, scoreboard pop/push.
  task automatic step(input logic iv, input logic orr, input stim_t s, output logic acc);
    @(negedge clk);
    if (stalled) begin
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_stable", out_result, held);
    end
    drive(iv, s);
    out_ready = orr;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", {31'h0, out_valid}, 32'h0);
      else chk("stream_result", out_result, sb.pop_front());
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(ref_model(s));
    stalled = out_valid && !out_ready;
    held    = out_result;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, v.s);
    #1;
    chk($sformatf("vec%0d_in_ready", idx), {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    chk($sformatf("vec%0d_result", idx), out_result, v.res);
  endtask

  function automatic stim_t mk(input logic sg, input logic [23:0] m, input logic [2:0] g,
                               input logic [7:0] e, input logic [9:0] sh,
                               input logic o, input logic u, input logic i);
    stim_t s;
    s.sign = sg; s.man = m; s.grs = g; s.exp = e; s.shift = sh;
    s.ovf = o; s.unf = u; s.inv = i;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int k;
    k = $urandom_range(0, 9);
    s.sign  = 1'($urandom_range(0, 1));
    s.man   = {1'b1, 23'($urandom)};
    s.grs   = 3'($urandom);
    s.exp   = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(1, 254));
    s.shift = 10'($urandom_range(1, 40));
    s.ovf = 1'b0; s.unf = 1'b0; s.inv = 1'b0;
    if (k == 0) s.man = 24'hFFFFFF;
    if (k >= 6 && k <= 7) begin
      s.unf = 1'b1;
      s.man = 24'($urandom);
      if ($urandom_range(0, 7) == 0) s.shift = 10'($urandom_range(41, 1023));
    end
    if (k == 8) begin s.ovf = 1'b1; s.unf = 1'($urandom_range(0, 1)); end
    if (k == 9) begin s.inv = 1'b1; s.ovf = 1'($urandom_range(0, 1)); s.unf = 1'($urandom_range(0, 1)); end
    return s;
  endfunction

  vec_t  tbl[13];
  stim_t sa, sb_s, sc, idle;
  logic  acc;
  int    guard;

  initial begin
    tbl[0]  = '{mk(0, 24'h800000, 3'b000, 8'h7F, 10'd0,  0, 0, 0), 32'h3F800000};
    tbl[1]  = '{mk(0, 24'h800001, 3'b100, 8'h7F, 10'd0,  0, 0, 0), 32'h3F800002};
    tbl[2]  = '{mk(0, 24'h800000, 3'b100, 8'h7F, 10'd0,  0, 0, 0), 32'h3F800000};
    tbl[3]  = '{mk(0, 24'hFFFFFF, 3'b110, 8'hFE, 10'd0,  0, 0, 0), 32'h7F800000};
    tbl[4]  = '{mk(0, 24'h800000, 3'b000, 8'h00, 10'd2,  0, 1, 0), 32'h00200000};
    tbl[5]  = '{mk(0, 24'h800000, 3'b000, 8'h00, 10'd30, 0, 1, 0), 32'h00000000};
    tbl[6]  = '{mk(1, 24'h800000, 3'b000, 8'h7F, 10'd0,  1, 1, 1), 32'h7FFFFFFF};
    tbl[7]  = '{mk(1, 24'h800000, 3'b000, 8'h7F, 10'd0,  1, 0, 0), 32'hFF800000};
    tbl[8]  = '{mk(1, 24'h800000, 3'b101, 8'h80, 10'd0,  0, 0, 0), 32'hC0000001};
    tbl[9]  = '{mk(0, 24'hFFFFFF, 3'b100, 8'h7F, 10'd0,  0, 0, 0), 32'h40000000};
    tbl[10] = '{mk(0, 24'hFFFFFF, 3'b000, 8'h00, 10'd1,  0, 1, 0), 32'h00800000};
    tbl[11] = '{mk(1, 24'h000001, 3'b001, 8'h00, 10'd1,  0, 1, 0), 32'h80000001};
    tbl[12] = '{mk(0, 24'h800000, 3'b000, 8'h10, 10'd0,  1, 1, 0), 32'h7F800000};
    idle = mk(0, 24'h0, 3'b0, 8'h0, 10'd0, 0, 0, 0);

    #2;
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_result", out_result, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Stall: two beats fill S1/S2, a third is refused until out_ready returns
    sa = tbl[0].s; sb_s = tbl[1].s; sc = tbl[3].s;
    step(1'b1, 1'b0, sa, acc);   chk("bp_acc_a", {31'h0, acc}, 32'h1);
    step(1'b1, 1'b0, sb_s, acc); chk("bp_acc_b", {31'h0, acc}, 32'h1);
    step(1'b1, 1'b0, sc, acc);   chk("bp_full", {31'h0, acc}, 32'h0);
    step(1'b1, 1'b0, sc, acc);   chk("bp_full2", {31'h0, acc}, 32'h0);
    chk("bp_head", out_result, 32'h3F800000);
    step(1'b1, 1'b1, sc, acc);   chk("bp_acc_c", {31'h0, acc}, 32'h1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, idle, acc);
    chk("bp_drained", sb.size(), 0);

    // Random stream with random backpressure and a mid-stream reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_out_result", out_result, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        sb.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_stim(), acc);
    end
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step(1'b0, 1'b1, idle, acc);
      guard++;
    end
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
